aha_tlx_fwd_arbiter: RTL and testbench



---
 rtl/aha_tlx_fwd_arbiter_if.sv | 31 +++
 rtl/aha_tlx_fwd_arbiter.sv | 129 ++++++++++++
 tb/tb_aha_tlx_fwd_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/aha_tlx_fwd_arbiter_if.sv
// Forward-payload bundle: per-source AXI-Stream inputs, link output, credit-return stream and status.
// master = the arbiter's view, slave = the sources/link side.
interface aha_tlx_fwd_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 40
);
  logic [NUM_SRC-1:0]        S_TVALID;
  logic [NUM_SRC-1:0]        S_TREADY;
  logic [NUM_SRC*DATA_W-1:0] S_TDATA;
  logic [NUM_SRC-1:0]        S_TLAST;
  logic                      M_TVALID;
  logic                      M_TREADY;
  logic [DATA_W-1:0]         M_TDATA;
  logic                      M_TLAST;
  logic [1:0]                M_TID;
  logic                      CRD_TVALID;
  logic                      CRD_TREADY;
  logic [1:0]                CRD_TDATA;
  logic [NUM_SRC-1:0]        CRD_EMPTY;
  logic                      ERR_STICKY;

  modport master (
    input  S_TVALID, S_TDATA, S_TLAST, M_TREADY, CRD_TVALID, CRD_TDATA,
    output S_TREADY, M_TVALID, M_TDATA, M_TLAST, M_TID, CRD_TREADY, CRD_EMPTY, ERR_STICKY
  );

  modport slave (
    output S_TVALID, S_TDATA, S_TLAST, M_TREADY, CRD_TVALID, CRD_TDATA,
    input  S_TREADY, M_TVALID, M_TDATA, M_TLAST, M_TID, CRD_TREADY, CRD_EMPTY, ERR_STICKY
  );
endinterface

// File: rtl/aha_tlx_fwd_arbiter.sv
// Credit-gated round-robin packet arbiter for the TLX forward payload channel.
// One idle arbitration cycle per packet, then beats pass combinationally; stalls on M_TREADY or zero credit.
module aha_tlx_fwd_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 40,
  parameter int CREDIT_MAX  = 8,
  parameter int CREDIT_INIT = 8
) (
  input logic                   TLX_SIB_CLK,
  input logic                   TLX_SIB_RESET,
  aha_tlx_fwd_arbiter_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [1:0]         grant;
  logic [1:0]         last;
  logic [1:0]         pick;
  logic [3:0]         credit [NUM_SRC];
  logic               err_sticky;
  logic               crd_rdy;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] inc_v;
  logic [NUM_SRC-1:0] dec_v;
  logic               any_elig;
  logic               g_vld;
  logic               g_crd;
  logic               g_last;
  logic [DATA_W-1:0]  g_dat;
  logic               fire;
  logic               crd_fire;
  logic               crd_bad;
  int                 best;

  always_comb begin
    elig   = '0;
    g_vld  = 1'b0;
    g_crd  = 1'b0;
    g_last = 1'b0;
    g_dat  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = bus.S_TVALID[i] && (credit[i] != 4'd0);
      if (grant == 2'(i)) begin
        g_vld  = bus.S_TVALID[i];
        g_crd  = (credit[i] != 4'd0);
        g_last = bus.S_TLAST[i];
        g_dat  = bus.S_TDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rank each eligible source by its distance after the last winner; the nearest one wins.
  always_comb begin
    best     = NUM_SRC;
    pick     = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && (((i - int'(last) - 1 + 2*NUM_SRC) % NUM_SRC) < best)) begin
        best     = (i - int'(last) - 1 + 2*NUM_SRC) % NUM_SRC;
        pick     = 2'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign fire     = (state == BUSY) && g_vld && g_crd && bus.M_TREADY;
  assign crd_fire = bus.CRD_TVALID && crd_rdy;
  assign crd_bad  = int'(bus.CRD_TDATA) >= NUM_SRC;

  always_comb begin
    bus.M_TVALID   = (state == BUSY) && g_vld && g_crd;
    bus.M_TDATA    = g_dat;
    bus.M_TLAST    = g_last;
    bus.M_TID      = grant;
    bus.CRD_TREADY = crd_rdy;
    bus.ERR_STICKY = err_sticky;
    bus.S_TREADY   = '0;
    bus.CRD_EMPTY  = '0;
    inc_v          = '0;
    dec_v          = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((state == BUSY) && (grant == 2'(i)))
        bus.S_TREADY[i] = bus.M_TREADY && g_crd;
      bus.CRD_EMPTY[i] = (credit[i] == 4'd0);
      inc_v[i]         = crd_fire && (bus.CRD_TDATA == 2'(i));
      dec_v[i]         = fire && (grant == 2'(i));
    end
  end

  always_ff @(posedge TLX_SIB_CLK) begin
    if (TLX_SIB_RESET) begin
      state      <= IDLE;
      grant      <= '0;
      last       <= 2'(NUM_SRC - 1);
      err_sticky <= 1'b0;
      crd_rdy    <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
        credit[i] <= 4'(CREDIT_INIT);
    end else begin
      crd_rdy <= 1'b1;
      case (state)
        IDLE: if (any_elig) begin
          grant <= pick;
          state <= BUSY;
        end
        BUSY: if (fire && g_last) begin
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (crd_fire && crd_bad)
        err_sticky <= 1'b1;
      // A return and a consumed beat on the same source cancel out.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          if (credit[i] >= 4'(CREDIT_MAX))
            err_sticky <= 1'b1;
          else
            credit[i] <= credit[i] + 4'd1;
        end else if (dec_v[i] && !inc_v[i]) begin
          credit[i] <= credit[i] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aha_tlx_fwd_arbiter.sv
// Directed bench: instance a is 4 sources / 8 credits, instance b is 3 sources / 2 initial credits.
module tb_aha_tlx_fwd_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  aha_tlx_fwd_arbiter_if #(.NUM_SRC(4), .DATA_W(40)) ifa ();
  aha_tlx_fwd_arbiter_if #(.NUM_SRC(3), .DATA_W(40)) ifb ();

  aha_tlx_fwd_arbiter #(.NUM_SRC(4), .DATA_W(40), .CREDIT_MAX(8), .CREDIT_INIT(8)) dut_a (
    .TLX_SIB_CLK(clk), .TLX_SIB_RESET(rst_a), .bus(ifa));

  aha_tlx_fwd_arbiter #(.NUM_SRC(3), .DATA_W(40), .CREDIT_MAX(8), .CREDIT_INIT(2)) dut_b (
    .TLX_SIB_CLK(clk), .TLX_SIB_RESET(rst_b), .bus(ifb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_a();
    ifa.S_TVALID = '0; ifa.S_TLAST = '0; ifa.CRD_TVALID = 1'b0; ifa.M_TREADY = 1'b1;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
  endtask

  task automatic reset_b();
    ifb.S_TVALID = '0; ifb.S_TLAST = '0; ifb.CRD_TVALID = 1'b0; ifb.M_TREADY = 1'b1;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.S_TVALID = '0; ifa.S_TLAST = '0; ifa.S_TDATA = '0; ifa.M_TREADY = 1'b1;
    ifa.CRD_TVALID = 1'b0; ifa.CRD_TDATA = '0;
    ifb.S_TVALID = '0; ifb.S_TLAST = '0; ifb.S_TDATA = '0; ifb.M_TREADY = 1'b1;
    ifb.CRD_TVALID = 1'b0; ifb.CRD_TDATA = '0;
    tick(); tick(); settle();

    // Reset state
    chk("rst_mvld", ifa.M_TVALID, 0);
    chk("rst_srdy", ifa.S_TREADY, 0);
    chk("rst_tid", ifa.M_TID, 0);
    chk("rst_crdrdy", ifa.CRD_TREADY, 0);
    chk("rst_empty", ifa.CRD_EMPTY, 0);
    chk("rst_err", ifa.ERR_STICKY, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); settle();
    chk("rel_crdrdy", ifa.CRD_TREADY, 1);

    // Single source, 3-beat packet
    ifa.S_TVALID = 4'b0001; ifa.S_TDATA[0 +: 40] = 40'hA0_0000_0001; settle();
    chk("ss_idle", ifa.M_TVALID, 0);
    tick(); settle();
    chk("ss_vld", ifa.M_TVALID, 1);
    chk("ss_tid", ifa.M_TID, 0);
    chk("ss_dat0", ifa.M_TDATA, 40'hA0_0000_0001);
    chk("ss_srdy", ifa.S_TREADY, 4'b0001);
    tick();
    ifa.S_TDATA[0 +: 40] = 40'hA0_0000_0002; ifa.M_TREADY = 1'b0; settle();
    chk("ss_crd7", dut_a.credit[0], 7);
    chk("ss_bp_srdy", ifa.S_TREADY, 0);
    tick(); ifa.M_TREADY = 1'b1; settle();
    chk("ss_bp_crd", dut_a.credit[0], 7);
    chk("ss_dat1", ifa.M_TDATA, 40'hA0_0000_0002);
    tick();
    ifa.S_TDATA[0 +: 40] = 40'hA0_0000_0003; ifa.S_TLAST = 4'b0001; settle();
    chk("ss_tlast", ifa.M_TLAST, 1);
    tick(); settle();
    chk("ss_back_idle", ifa.M_TVALID, 0);
    chk("ss_crd5", dut_a.credit[0], 5);

    // Round robin over four sources with 1-beat packets
    reset_a();
    ifa.S_TVALID = 4'b1111; ifa.S_TLAST = 4'b1111;
    for (int i = 0; i < 4; i++) ifa.S_TDATA[i*40 +: 40] = 40'h100 + 40'(i);
    settle();
    chk("rr_start_idle", ifa.M_TVALID, 0);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      chk("rr_vld", ifa.M_TVALID, 1);
      chk("rr_tid", ifa.M_TID, 64'(k % 4));
      chk("rr_dat", ifa.M_TDATA, 64'h100 + 64'(k % 4));
      tick(); settle();
      chk("rr_gap", ifa.M_TVALID, 0);
    end

    // Simultaneous consume and return on source 2
    reset_a();
    ifa.S_TVALID = 4'b0100; ifa.S_TLAST = 4'b0100;
    tick(); settle();
    chk("sim_tid", ifa.M_TID, 2);
    chk("sim_vld", ifa.M_TVALID, 1);
    ifa.CRD_TVALID = 1'b1; ifa.CRD_TDATA = 2'd2;
    tick();
    ifa.CRD_TVALID = 1'b0; ifa.S_TVALID = '0; settle();
    chk("sim_crd", dut_a.credit[2], 8);
    chk("sim_err", ifa.ERR_STICKY, 0);

    // Overflow return to a full source
    ifa.CRD_TVALID = 1'b1; ifa.CRD_TDATA = 2'd0;
    tick();
    ifa.CRD_TVALID = 1'b0; settle();
    chk("ovf_crd", dut_a.credit[0], 8);
    chk("ovf_err", ifa.ERR_STICKY, 1);
    tick(); tick(); tick(); settle();
    chk("ovf_hold", ifa.ERR_STICKY, 1);
    reset_a(); settle();
    chk("ovf_clr", ifa.ERR_STICKY, 0);

    // Credit stall on source 1 of instance b
    reset_b();
    ifb.S_TVALID = 3'b010; ifb.S_TDATA[40 +: 40] = 40'hB0; settle();
    chk("cs_idle", ifb.M_TVALID, 0);
    tick(); settle();
    chk("cs_vld0", ifb.M_TVALID, 1);
    chk("cs_tid0", ifb.M_TID, 1);
    tick(); ifb.S_TDATA[40 +: 40] = 40'hB1; settle();
    chk("cs_vld1", ifb.M_TVALID, 1);
    tick(); ifb.S_TDATA[40 +: 40] = 40'hB2; settle();
    chk("cs_stall", ifb.M_TVALID, 0);
    chk("cs_empty", ifb.CRD_EMPTY, 3'b010);
    chk("cs_srdy", ifb.S_TREADY, 0);
    ifb.S_TVALID = 3'b011;
    tick(); settle();
    chk("cs_hold_vld", ifb.M_TVALID, 0);
    chk("cs_hold_tid", ifb.M_TID, 1);
    ifb.CRD_TVALID = 1'b1; ifb.CRD_TDATA = 2'd1;
    tick(); ifb.CRD_TVALID = 1'b0; settle();
    chk("cs_b3_vld", ifb.M_TVALID, 1);
    chk("cs_b3_dat", ifb.M_TDATA, 40'hB2);
    chk("cs_b3_tid", ifb.M_TID, 1);
    tick(); ifb.S_TDATA[40 +: 40] = 40'hB3; ifb.S_TLAST = 3'b010; settle();
    chk("cs_stall2", ifb.M_TVALID, 0);
    ifb.CRD_TVALID = 1'b1; ifb.CRD_TDATA = 2'd1;
    tick(); ifb.CRD_TVALID = 1'b0; settle();
    chk("cs_b4_vld", ifb.M_TVALID, 1);
    chk("cs_b4_last", ifb.M_TLAST, 1);
    chk("cs_b4_tid", ifb.M_TID, 1);
    tick(); ifb.S_TVALID = 3'b001; ifb.S_TLAST = 3'b001; settle();
    chk("cs_end_idle", ifb.M_TVALID, 0);
    tick(); settle();
    chk("cs_next_tid", ifb.M_TID, 0);
    chk("cs_next_vld", ifb.M_TVALID, 1);

    // Illegal return index on the 3-source instance
    reset_b();
    ifb.CRD_TVALID = 1'b1; ifb.CRD_TDATA = 2'd3;
    tick(); ifb.CRD_TVALID = 1'b0; settle();
    chk("ill_err", ifb.ERR_STICKY, 1);
    for (int i = 0; i < 3; i++) chk("ill_crd", dut_b.credit[i], 2);
    tick(); tick(); settle();
    chk("ill_hold", ifb.ERR_STICKY, 1);
    reset_b(); settle();
    chk("ill_clr", ifb.ERR_STICKY, 0);

    // Reset during beat 2 of a 4-beat packet
    reset_a();
    ifa.S_TVALID = 4'b1000; ifa.S_TLAST = 4'b0000;
    tick(); settle();
    chk("rm_tid", ifa.M_TID, 3);
    chk("rm_vld", ifa.M_TVALID, 1);
    tick(); settle();
    chk("rm_crd7", dut_a.credit[3], 7);
    rst_a = 1'b1;
    tick(); settle();
    chk("rm_mvld", ifa.M_TVALID, 0);
    chk("rm_srdy", ifa.S_TREADY, 0);
    for (int i = 0; i < 4; i++) chk("rm_crd", dut_a.credit[i], 8);
    rst_a = 1'b0; ifa.S_TVALID = 4'b1111;
    tick(); settle();
    chk("rm_arb_tid", ifa.M_TID, 0);
    chk("rm_arb_vld", ifa.M_TVALID, 1);
    ifa.S_TVALID = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
